ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends one command byte, for example set-LEDs 0xED or reset 0xFF, to the keyboard over the shared PS2_CLK/PS2_DAT open-collector lines. It is the outbound counterpart to ps2_kbd and sits beside it in toplevel. The HPS launches it through a PIO, and it returns ack/error status through a PIO.
- While busy, it tells ps2_kbd to ignore line activity, so the device's ACK clocking is not decoded as a scancode.

---
 rtl/ps2_pkg.sv | 36 +++
 rtl/ps2_host_tx_if.sv | 28 ++
 rtl/ps2_line_sync.sv | 39 +++
 rtl/ps2_host_tx.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host blocks.
//   ps2_state_e : host transmitter FSM states (also exported for debug)
//   tx_status_e : completion codes reported with tx_done
//   CMD_*       : common keyboard command bytes
//   odd_parity  : parity bit that makes the 9-bit data+parity word odd
package ps2_pkg;

  localparam int TMR_W = 20;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE,
    DONE
  } ps2_state_e;

  typedef enum logic [1:0] {
    TX_OK        = 2'b00,
    TX_NO_ACK    = 2'b01,
    TX_START_TMO = 2'b10,
    TX_FRAME_TMO = 2'b11
  } tx_status_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command/status bundle between the HPS PIO side (master)
// and the PS/2 host transmitter (slave).
//   tx_valid/tx_data : command request and byte
//   tx_ready         : transmitter idle and able to accept
//   tx_done          : one-cycle completion pulse
//   tx_status        : result code, valid from tx_done until the next completion
//   busy             : transfer in progress
// Handshake: a command is taken on a clock edge where tx_valid && tx_ready;
// tx_data must be stable in that cycle. tx_valid while tx_ready is low is
// dropped, never queued, so the master must wait for tx_ready again.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic [1:0] tx_status;
  logic       busy;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx_done, tx_status, busy
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx_done, tx_status, busy
  );
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizers for raw PS2_CLK/PS2_DAT pins plus a
// registered falling-edge strobe of the clock line.
//   clk, reset_n : system clock, async active-low reset
//   clk_in/dat_in: raw pin levels
//   clk_s/dat_s  : synchronized levels (reset to idle-high)
//   fe           : one-cycle pulse per synchronized 1->0 of the clock line
module ps2_line_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic clk_in,
  input  logic dat_in,
  output logic clk_s,
  output logic dat_s,
  output logic fe
);

  logic clk_meta;
  logic dat_meta;
  logic clk_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta <= 1'b1;
      clk_s    <= 1'b1;
      clk_d    <= 1'b1;
      dat_meta <= 1'b1;
      dat_s    <= 1'b1;
      fe       <= 1'b0;
    end else begin
      clk_meta <= clk_in;
      clk_s    <= clk_meta;
      clk_d    <= clk_s;
      dat_meta <= dat_in;
      dat_s    <= dat_meta;
      fe       <= clk_d & ~clk_s;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the bus, issues request-to-send, shifts out one byte with odd
// parity on device clock falling edges, then checks the device ACK bit.
//   clk, reset_n            : CLOCK_50, async active-low reset
//   host                    : command/status interface (slave side)
//   ps2_clk_in/ps2_dat_in   : raw pin levels
//   ps2_clk_oe/ps2_dat_oe   : 1 pulls the open-collector line low
//   dbg_state               : current FSM state
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYC   = 6000,
  parameter int unsigned START_CYC     = 250,
  parameter int unsigned START_TMO_CYC = 750000,
  parameter int unsigned FRAME_TMO_CYC = 100000
) (
  input  logic            clk,
  input  logic            reset_n,
  ps2_host_tx_if.slave    host,
  input  logic            ps2_clk_in,
  input  logic            ps2_dat_in,
  output logic            ps2_clk_oe,
  output logic            ps2_dat_oe,
  output ps2_state_e      dbg_state
);

  localparam logic [TMR_W-1:0] INH_LAST  = TMR_W'(INHIBIT_CYC - 1);
  localparam logic [TMR_W-1:0] STA_LAST  = TMR_W'(START_CYC - 1);
  localparam logic [TMR_W-1:0] STMO_LAST = TMR_W'(START_TMO_CYC - 1);
  localparam logic [TMR_W-1:0] FTMO_LAST = TMR_W'(FRAME_TMO_CYC - 1);

  logic clk_s, dat_s, fe;

  ps2_line_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_in  (ps2_clk_in),
    .dat_in  (ps2_dat_in),
    .clk_s   (clk_s),
    .dat_s   (dat_s),
    .fe      (fe)
  );

  ps2_state_e       state_q, state_d;
  logic [TMR_W-1:0] tmr_q;
  logic [9:0]       sh_q;      // {stop, parity, data[7:0]}, bit 0 goes out next
  logic [3:0]       bit_cnt_q;
  logic             dat_oe_q;
  logic             ack_ok_q;
  tx_status_e       status_q, status_d;
  logic             tmr_clr;
  logic             frame_tmo;
  logic             frame_hold;

  assign frame_tmo = (tmr_q == FTMO_LAST);

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    case (state_q)
      IDLE:      if (host.tx_valid) state_d = INHIBIT;
      INHIBIT:   if (tmr_q == INH_LAST) state_d = START;
      START:     if (tmr_q == STA_LAST) state_d = REQ;
      REQ: begin
        if (fe) begin
          state_d = SEND;
        end else if (tmr_q == STMO_LAST) begin
          state_d  = DONE;
          status_d = TX_START_TMO;
        end
      end
      SEND: begin
        if (frame_tmo) begin
          state_d  = DONE;
          status_d = TX_FRAME_TMO;
        end else if (fe && bit_cnt_q == 4'd8) begin
          state_d = ACK;
        end
      end
      ACK: begin
        if (frame_tmo) begin
          state_d  = DONE;
          status_d = TX_FRAME_TMO;
        end else if (fe) begin
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (frame_tmo) begin
          state_d  = DONE;
          status_d = TX_FRAME_TMO;
        end else if (clk_s && dat_s) begin
          state_d  = DONE;
          status_d = ack_ok_q ? TX_OK : TX_NO_ACK;
        end
      end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // The frame timer spans SEND..WAIT_IDLE, so those hand-overs keep it running.
  assign frame_hold = (state_q == SEND && state_d == ACK) ||
                      (state_q == ACK  && state_d == WAIT_IDLE);
  assign tmr_clr    = (state_d != state_q) && !frame_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      sh_q      <= '1;
      bit_cnt_q <= '0;
      dat_oe_q  <= 1'b0;
      ack_ok_q  <= 1'b0;
      status_q  <= TX_OK;
    end else begin
      state_q <= state_d;

      if (tmr_clr)           tmr_q <= '0;
      else if (tmr_q != '1)  tmr_q <= tmr_q + 1'b1;

      if (state_q == IDLE && host.tx_valid)
        sh_q <= {1'b1, odd_parity(host.tx_data), host.tx_data};

      // fe #1 (in REQ) presents data bit 0; each later fe presents the next
      // bit. Shifting in ones makes the stop bit release the line.
      if (state_q == REQ && fe) begin
        bit_cnt_q <= '0;
        dat_oe_q  <= ~sh_q[0];
        sh_q      <= {1'b1, sh_q[9:1]};
      end else if (state_q == SEND && fe && !frame_tmo) begin
        bit_cnt_q <= bit_cnt_q + 4'd1;
        dat_oe_q  <= ~sh_q[0];
        sh_q      <= {1'b1, sh_q[9:1]};
      end

      if (state_q == ACK && fe) ack_ok_q <= ~dat_s;

      if (state_d == DONE) status_q <= status_d;
    end
  end

  // Line drives decode straight from state so an async reset frees the bus
  // without waiting for a clock edge.
  always_comb begin
    ps2_clk_oe = (state_q == INHIBIT) || (state_q == START);
    ps2_dat_oe = 1'b0;
    case (state_q)
      START, REQ: ps2_dat_oe = 1'b1;
      SEND:       ps2_dat_oe = dat_oe_q;
      default:    ps2_dat_oe = 1'b0;
    endcase
  end

  assign host.tx_ready  = (state_q == IDLE);
  assign host.busy      = (state_q != IDLE);
  assign host.tx_done   = (state_q == DONE);
  assign host.tx_status = status_q;
  assign dbg_state      = state_q;

endmodule
